// File: rtl/dw_cntr_gray.sv
// ---------------------------------------------------------------------------
// dw_cntr_gray
//
// Registered, parametrised Gray-code counter. The count state lives in a
// binary register (b_q); a second register (g_q) is loaded with the Gray
// encoding of the same next value, so both outputs come straight from flops.
// Intended as a pointer generator for async FIFOs and clock-domain crossings:
// every enabled count that changes the value flips exactly one bit of g.
//
// Parameters:
//   width    - count width in bits (2..32)
//   sat_mode - 0: wrap at the terminal value, 1: hold at the terminal value
//   init_val - binary value taken while rst_n is low (must be < 2^width)
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   clr      in   synchronous clear to 0 (highest priority)
//   ld       in   synchronous load of ld_data (Gray coded)
//   ld_data  in   [width-1:0] Gray-coded load value
//   en       in   count enable
//   up_dn    in   1 = count up, 0 = count down
//   g        out  [width-1:0] registered Gray count
//   b        out  [width-1:0] registered binary equivalent of g
//   tc       out  terminal count: at max while counting up, at 0 while down
// ---------------------------------------------------------------------------
module dw_cntr_gray #(
    parameter int          width    = 8,
    parameter int          sat_mode = 0,
    parameter logic [31:0] init_val = 32'd0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             ld,
    input  logic [width-1:0] ld_data,
    input  logic             en,
    input  logic             up_dn,
    output logic [width-1:0] g,
    output logic [width-1:0] b,
    output logic             tc
);

    // Reset values in both codings, derived once from the binary init_val.
    localparam logic [width-1:0] INIT_B  = init_val[width-1:0];
    localparam logic [width-1:0] INIT_G  = INIT_B ^ (INIT_B >> 1);
    localparam logic [width-1:0] MAX_VAL = {width{1'b1}};
    localparam logic [width-1:0] ONE     = {{(width-1){1'b0}}, 1'b1};

    logic [width-1:0] b_q;
    logic [width-1:0] g_q;
    logic [width-1:0] b_next;
    logic             at_max;
    logic             at_zero;

    // Gray to binary: each binary bit is the XOR of all Gray bits at and
    // above it, built from the MSB downwards as a running XOR.
    function automatic logic [width-1:0] gray2bin(input logic [width-1:0] gray);
        logic [width-1:0] bin;
        bin[width-1] = gray[width-1];
        for (int i = width - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    // Binary to Gray: each Gray bit is the XOR of adjacent binary bits.
    function automatic logic [width-1:0] bin2gray(input logic [width-1:0] bin);
        logic [width-1:0] gray;
        for (int i = 0; i < width - 1; i++) begin
            gray[i] = bin[i] ^ bin[i+1];
        end
        gray[width-1] = bin[width-1];
        return gray;
    endfunction

    assign at_max  = (b_q == MAX_VAL);
    assign at_zero = (b_q == '0);

    // Next binary value with clr > ld > en priority. At the terminal value
    // the counter either wraps (modulo arithmetic does that for free) or,
    // in saturate mode, simply keeps its current value so g never moves.
    always_comb begin
        b_next = b_q;
        if (clr) begin
            b_next = '0;
        end else if (ld) begin
            b_next = gray2bin(ld_data);
        end else if (en) begin
            if (up_dn) begin
                if (at_max && (sat_mode != 0)) begin
                    b_next = b_q;
                end else begin
                    b_next = b_q + ONE;
                end
            end else begin
                if (at_zero && (sat_mode != 0)) begin
                    b_next = b_q;
                end else begin
                    b_next = b_q - ONE;
                end
            end
        end
    end

    // Both codings are registered from the same next value, so g is never
    // decoded combinationally from b and stays glitch-free for CDC use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q <= INIT_B;
            g_q <= INIT_G;
        end else begin
            b_q <= b_next;
            g_q <= bin2gray(b_next);
        end
    end

    assign g  = g_q;
    assign b  = b_q;

    // Terminal count follows up_dn immediately and ignores en.
    assign tc = up_dn ? at_max : at_zero;

endmodule
